// File: rtl/uart_rx_word_framer_pkg.sv
// Shared types and constants for the UART receive word framer.
package uart_rx_word_framer_pkg;

    localparam int UART_WIDTH = 8;

    typedef enum logic {
        IDLE     = 1'b0,
        ASSEMBLE = 1'b1
    } asm_state_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    function automatic int bytes_per_word(input int width);
        return (width + UART_WIDTH - 1) / UART_WIDTH;
    endfunction

endpackage

// File: rtl/uart_rx_word_framer_if.sv
// AXI-Stream style valid/ready channel used on both sides of the framer.
interface uart_rx_word_framer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_word_framer_idle_timer.sv
// Inter-byte idle timer: expire pulses when run has been held for TIMEOUT_CYCLES cycles.
// TIMEOUT_CYCLES == 0 removes the timer entirely.
module uart_rx_word_framer_idle_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic arstn,
    input  logic clr,
    input  logic run,
    output logic expire
);
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_in;
            assign unused_in = &{1'b0, clk, arstn, clr, run};
            assign expire    = 1'b0;
        end else begin : g_on
            localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

            logic [TW-1:0] timer;

            assign expire = run && !clr && (timer == LAST);

            always_ff @(posedge clk or negedge arstn) begin
                if (!arstn) begin
                    timer <= '0;
                end else if (clr || expire) begin
                    timer <= '0;
                end else if (run) begin
                    timer <= timer + TW'(1);
                end
            end
        end
    endgenerate
endmodule

// File: rtl/uart_rx_word_framer.sv
// Packs consecutive UART bytes (first byte most significant) into M_WIDTH-bit words.
// Defining FRAME_SYNC_DROP_COUNT_EN adds a saturating 16-bit drop_count debug port.
module uart_rx_word_framer
    import uart_rx_word_framer_pkg::*;
#(
    parameter int S_WIDTH        = UART_WIDTH,
    parameter int M_WIDTH        = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  arstn,
    uart_rx_word_framer_if.slave  s_axis,
    uart_rx_word_framer_if.master m_axis,
    output logic                  sync_drop
`ifdef FRAME_SYNC_DROP_COUNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);
    // state    | meaning
    // IDLE     | no partial word held (cnt == 0)
    // ASSEMBLE | 1..N-1 bytes of a word collected, idle timer armed
    // EMPTY    | output register free
    // FULL     | output word waiting for m_axis_tready

    localparam int N  = bytes_per_word(M_WIDTH);
    localparam int SW = N * UART_WIDTH;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    asm_state_e         asm_state, asm_next;
    out_state_e         out_state, out_next;
    logic [CW-1:0]      cnt, cnt_next;
    logic [SW-1:0]      shreg, shreg_next, shifted;
    logic [M_WIDTH-1:0] word_q;
    logic               ready_en, accept, complete, load, out_take, expire;

    // Only the completing byte has to wait for the output slot.
    assign s_axis.tready = ready_en &&
                           !(cnt == LAST_CNT && out_state == FULL && !m_axis.tready);
    assign accept   = s_axis.tvalid && s_axis.tready;
    assign complete = accept && (cnt == LAST_CNT);
    assign out_take = (out_state == FULL) && m_axis.tready;
    assign shifted  = (shreg << UART_WIDTH) | SW'(s_axis.tdata[S_WIDTH-1:0]);

    assign m_axis.tvalid = (out_state == FULL);
    assign m_axis.tdata  = word_q;

    uart_rx_word_framer_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk   (clk),
        .arstn (arstn),
        .clr   (accept || asm_state == IDLE),
        .run   (asm_state == ASSEMBLE && !s_axis.tvalid),
        .expire(expire)
    );

    always_comb begin
        asm_next   = asm_state;
        cnt_next   = cnt;
        shreg_next = shreg;
        load       = 1'b0;
        if (complete) begin
            asm_next   = IDLE;
            cnt_next   = '0;
            shreg_next = '0;
            load       = 1'b1;
        end else if (accept) begin
            asm_next   = ASSEMBLE;
            cnt_next   = cnt + CW'(1);
            shreg_next = shifted;
        end else if (expire) begin
            asm_next   = IDLE;
            cnt_next   = '0;
            shreg_next = '0;
        end
    end

    always_comb begin
        out_next = out_state;
        if (load) begin
            out_next = FULL;
        end else if (out_take) begin
            out_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            asm_state <= IDLE;
            out_state <= EMPTY;
            cnt       <= '0;
            shreg     <= '0;
            word_q    <= '0;
            sync_drop <= 1'b0;
            ready_en  <= 1'b0;
        end else begin
            asm_state <= asm_next;
            out_state <= out_next;
            cnt       <= cnt_next;
            shreg     <= shreg_next;
            sync_drop <= expire;
            ready_en  <= 1'b1;
            if (load) begin
                word_q <= M_WIDTH'(shifted);
            end
        end
    end

`ifdef FRAME_SYNC_DROP_COUNT_EN
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            drop_count <= '0;
        end else if (sync_drop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif
endmodule

// File: doc/uart_rx_word_framer.md
Name: uart_rx_word_framer

Overview:
- Sits between the UART receive byte stream and the processor input port.
- Assembles consecutive 8-bit AXI-Stream beats into one M_WIDTH-bit word. The first byte received is the most significant.
- Provides resynchronisation with an inter-byte idle timeout: a partial word that stalls on the serial line is discarded, so host and processor realign on the next word boundary.
- Emits one registered output word per complete group of bytes, with full AXI-Stream backpressure on both sides.

Parameters:
- S_WIDTH, 8, input beat width in bits; fixed at 8 for 8N1 UART.
- M_WIDTH, 32, output word width in bits; normally set to processor_config::INP_WIDTH. Must be at least 1.
- TIMEOUT_CYCLES, 100000, number of idle clock cycles after which a partial word is dropped. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- arstn  in  1  asynchronous active-low reset
- s_axis_tdata  in  S_WIDTH  received byte
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  byte accepted when high together with tvalid
- m_axis_tdata  out  M_WIDTH  assembled word
- m_axis_tvalid  out  1  word valid
- m_axis_tready  in  1  downstream ready
- sync_drop  out  1  one-cycle pulse when a partial word is discarded

Behaviour:
- Interface: one clock, clk; reset arstn is asynchronous, active-low.
- Derived constants:
  - N = ceil(M_WIDTH/8) bytes per word.
  - PAD = N*8 - M_WIDTH.
  - cnt is a $clog2(N+1)-bit byte counter.
  - timer is a $clog2(TIMEOUT_CYCLES+1)-bit counter.
- Reset values: shift register 0, cnt 0, timer 0, m_axis_tvalid 0, m_axis_tdata 0, sync_drop 0. s_axis_tready is 1 one cycle after arstn deasserts.
- Byte acceptance (accept = s_axis_tvalid & s_axis_tready):
  - Data shifts into the low byte; earlier bytes move up by 8.
  - cnt increments on each accepted byte.
- Word completion: when cnt == N-1 and a byte is accepted:
  - m_axis_tdata is loaded with the low M_WIDTH bits of the N*8-bit assembly. The top PAD bits of the first byte are discarded.
  - m_axis_tvalid rises on the next cycle; cnt returns to 0.
  - Latency: last byte accepted at cycle T gives tvalid at cycle T+1.
- Output register:
  - m_axis_tvalid stays high and m_axis_tdata stays stable until m_axis_tready is sampled high.
  - If a completing byte is accepted in the same cycle as the output handshake, the new word loads with no bubble.
- s_axis_tready = !(cnt == N-1 && m_axis_tvalid && !m_axis_tready).
  - Bytes 0..N-2 of the next word are always accepted, even while the output is stalled.
  - Only the completing byte waits for the output slot.
- N == 1: every byte is a word, and s_axis_tready = !m_axis_tvalid | m_axis_tready.
- Timeout, active only when TIMEOUT_CYCLES > 0:
  - timer clears on every accepted byte and whenever cnt == 0.
  - timer increments each cycle when cnt > 0 and s_axis_tvalid is low.
  - timer holds when s_axis_tvalid is high but tready is low, so a stall is never counted as line idle.
  - When timer == TIMEOUT_CYCLES-1 and it would increment: cnt and the shift register clear, timer clears, and sync_drop pulses for one cycle on the next cycle.
  - If a byte is accepted in the same cycle as the timeout, the byte wins: it is accepted and no drop occurs.
- A completed word already in the output register is never affected by a timeout.
- Reset mid-word: all state clears immediately; any partial or pending word is lost, with no sync_drop pulse.
- Shift register state machine (cnt, timer) has two states:
  - IDLE: cnt == 0.
  - ASSEMBLE: cnt > 0.
  - IDLE to ASSEMBLE on an accepted byte when N > 1.
  - ASSEMBLE to IDLE on word completion or on timeout.
- Output register states: EMPTY and FULL. It fills on completion and empties on the output handshake.

Optional Feature:
- Macro: FRAME_SYNC_DROP_COUNT_EN.
- Defined:
  - Adds output port drop_count, 16 bits.
  - It is a saturating counter of sync_drop pulses: it increments on each pulse, holds at 0xFFFF, and resets to 0 on arstn.
  - uart_processor exposes it for debug LEDs or ILA.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Decomposition:
- Shared package (processor_config or a new framer_pkg):
  - asm_state_e (IDLE, ASSEMBLE) and out_state_e (EMPTY, FULL) enum typedefs.
  - The UART_WIDTH = 8 constant, shared with uart_processor.
  - A helper function bytes_per_word(width) returning ceil(width/8).
- One natural sub-module, idle_timer, containing:
  - Parameter TIMEOUT_CYCLES.
  - Inputs clr and run; output expire (one-cycle).
  - When TIMEOUT_CYCLES == 0 it ties expire low.

Test Plan:
- M_WIDTH=24: send 0x12, 0x34, 0x56 back-to-back with m_axis_tready=1 → m_axis_tdata=0x123456, tvalid high exactly one cycle after 0x56 is accepted.
- M_WIDTH=20: send 0xA1, 0x23, 0x45 → m_axis_tdata=0x12345 (top nibble 0xA dropped).
- M_WIDTH=24, TIMEOUT_CYCLES=16:
  - Send 0xAA, 0xBB, then idle 16 cycles → sync_drop pulses once.
  - Then send 0x01, 0x02, 0x03 → word 0x010203; 0xAA/0xBB never appear.
  - With FRAME_SYNC_DROP_COUNT_EN defined, drop_count = 1.
- M_WIDTH=16, m_axis_tready=0, send 0x11, 0x22, 0x33, 0x44:
  - Word 0x1122 is held.
  - 0x33 is accepted; 0x44 is stalled (s_axis_tready=0) and the timer holds past TIMEOUT_CYCLES.
  - Raise tready → 0x1122 then 0x3344, no drop.
- Assert arstn low after 2 of 4 bytes (M_WIDTH=32), release, then send 0xDE, 0xAD, 0xBE, 0xEF → single word 0xDEADBEEF; all outputs at reset values during reset.
- M_WIDTH=8: random 256-byte stream with random tready → output sequence equals input sequence; no drops, no duplicates.
